dice_roller_multi: RTL and testbench

//  Parametrised multi-die roller: NUM_DICE independent dice, each with FACES faces (values 1..FACES).
//  A roll request starts a fixed-length spin: each un-held die advances by pseudo-random steps from a free-running LFSR.
//  At the end of the spin the block reports the final values, their sum and an all-equal flag.

---
 rtl/dice_roller_multi.sv | 145 ++++++++++++++
 tb/tb_dice_roller_multi.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller_multi.sv
// Multi-die roller: an LFSR-driven spin of NUM_DICE dice with FACES faces each.
// Reports the final values, their sum and an all-equal flag with a done pulse.
module dice_roller_multi #(
   parameter int unsigned  NUM_DICE    = 2,
   parameter int unsigned  FACES       = 6,
   parameter int unsigned  SPIN_CYCLES = 8,
   parameter logic [15:0]  LFSR_SEED   = 16'hACE1,
   localparam int unsigned VAL_W       = $clog2(FACES + 1),
   localparam int unsigned SUM_W       = $clog2(NUM_DICE * FACES + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      roll,
   input  logic [NUM_DICE-1:0]       hold,
   input  logic                      seq_mode,
   output logic [NUM_DICE*VAL_W-1:0] dice_values,
   output logic [SUM_W-1:0]          sum,
   output logic                      all_equal,
   output logic                      busy,
   output logic                      done
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SPIN = 1'b1;

   localparam int unsigned       TW      = VAL_W + 3;
   localparam logic [TW-1:0]     FACES_T = TW'(FACES);
   localparam logic [7:0]        SPIN_N  = 8'(SPIN_CYCLES);

   if (NUM_DICE < 1 || NUM_DICE > 8) begin : g_bad_num_dice
      $error("dice_roller_multi: NUM_DICE must be 1..8");
   end
   if (FACES < 2 || FACES > 15) begin : g_bad_faces
      $error("dice_roller_multi: FACES must be 2..15");
   end
   if (SPIN_CYCLES < 1 || SPIN_CYCLES > 255) begin : g_bad_spin
      $error("dice_roller_multi: SPIN_CYCLES must be 1..255");
   end
   if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("dice_roller_multi: LFSR_SEED must be non-zero");
   end

   logic [0:0]          state;
   logic [15:0]         lfsr;
   logic [7:0]          cnt;
   logic [NUM_DICE-1:0] hold_q;
   logic                seq_q;
   logic [VAL_W-1:0]    die      [NUM_DICE];
   logic [VAL_W-1:0]    die_next [NUM_DICE];
   logic [SUM_W-1:0]    sum_next;
   logic                eq_next;
   logic                lfsr_fb;

   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   // Modulo on a widened value keeps the result in 1..FACES even when step > FACES.
   function automatic logic [VAL_W-1:0] advance(input logic [VAL_W-1:0] v,
                                                 input logic [2:0]       step);
      logic [TW-1:0] t;
      logic [TW-1:0] r;
      t = {3'b000, v} + {{VAL_W{1'b0}}, step} - TW'(1);
      r = (t % FACES_T) + TW'(1);
      return r[VAL_W-1:0];
   endfunction

   always_comb begin
      logic [2:0] step;
      for (int unsigned i = 0; i < NUM_DICE; i++) begin
         step = 3'd1;
         if (!seq_q) begin
            step = 3'd1 + {1'b0, lfsr[2*i +: 2]};
         end
         if (hold_q[i]) begin
            die_next[i] = die[i];
         end else begin
            die_next[i] = advance(die[i], step);
         end
      end
   end

   always_comb begin
      sum_next = '0;
      eq_next  = 1'b1;
      for (int unsigned i = 0; i < NUM_DICE; i++) begin
         sum_next = sum_next + SUM_W'(die_next[i]);
         if (die_next[i] != die_next[0]) begin
            eq_next = 1'b0;
         end
      end
   end

   always_comb begin
      dice_values = '0;
      for (int unsigned i = 0; i < NUM_DICE; i++) begin
         dice_values[i*VAL_W +: VAL_W] = die[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         lfsr      <= LFSR_SEED;
         cnt       <= '0;
         hold_q    <= '0;
         seq_q     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= SUM_W'(NUM_DICE);
         all_equal <= 1'b1;
         for (int unsigned i = 0; i < NUM_DICE; i++) begin
            die[i] <= VAL_W'(1);
         end
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (roll) begin
                  state  <= ST_SPIN;
                  cnt    <= SPIN_N;
                  hold_q <= hold;
                  seq_q  <= seq_mode;
                  busy   <= 1'b1;
               end
            end
            ST_SPIN: begin
               for (int unsigned i = 0; i < NUM_DICE; i++) begin
                  die[i] <= die_next[i];
               end
               cnt <= cnt - 8'd1;
               // The final advance and the result load share one edge.
               if (cnt == 8'd1) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  sum       <= sum_next;
                  all_equal <= eq_next;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dice_roller_multi.sv
// Self-checking bench: directed steps plus random rolls against a behavioural model
// for a default 2x6 roller and an 8x3 single-cycle roller.
module tb_dice_roller_multi;

   logic        clk;
   logic        reset;
   logic        roll_a, seq_a;
   logic [1:0]  hold_a;
   logic [5:0]  dice_a;
   logic [3:0]  sum_a;
   logic        eq_a, busy_a, done_a;
   logic        roll_b, seq_b;
   logic [7:0]  hold_b;
   logic [15:0] dice_b;
   logic [4:0]  sum_b;
   logic        eq_b, busy_b, done_b;

   dice_roller_multi #(.NUM_DICE(2), .FACES(6), .SPIN_CYCLES(8), .LFSR_SEED(16'hACE1)) dut_a (
      .clk(clk), .reset(reset), .roll(roll_a), .hold(hold_a), .seq_mode(seq_a),
      .dice_values(dice_a), .sum(sum_a), .all_equal(eq_a), .busy(busy_a), .done(done_a));

   dice_roller_multi #(.NUM_DICE(8), .FACES(3), .SPIN_CYCLES(1), .LFSR_SEED(16'hACE1)) dut_b (
      .clk(clk), .reset(reset), .roll(roll_b), .hold(hold_b), .seq_mode(seq_b),
      .dice_values(dice_b), .sum(sum_b), .all_equal(eq_b), .busy(busy_b), .done(done_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned nd [2] = '{2, 8};
   int unsigned fc [2] = '{6, 3};
   int unsigned sc [2] = '{8, 1};
   int unsigned vw [2] = '{3, 2};

   int unsigned m_dice [2][8];
   int unsigned m_lfsr [2];
   int unsigned m_cnt  [2];
   int unsigned m_hold [2];
   int unsigned m_sum  [2];
   bit          m_seq  [2];
   bit          m_busy [2];
   bit          m_done [2];
   bit          m_eq   [2];

   int n_checks = 0;
   int n_pass   = 0;
   bit b_active = 0;

   function automatic int unsigned lfsr_next(input int unsigned l);
      int unsigned b;
      b = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
      return ((l << 1) | b) & 32'hFFFF;
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 8; i++) m_dice[u][i] = 1;
         m_lfsr[u] = 32'hACE1;
         m_cnt[u]  = 0;
         m_hold[u] = 0;
         m_seq[u]  = 0;
         m_busy[u] = 0;
         m_done[u] = 0;
         m_sum[u]  = nd[u];
         m_eq[u]   = 1;
      end
   endtask

   task automatic model_edge(input int u, input bit r, input int unsigned h, input bit s);
      int unsigned stp;
      m_done[u] = 0;
      if (!m_busy[u]) begin
         if (r) begin
            m_busy[u] = 1;
            m_cnt[u]  = sc[u];
            m_hold[u] = h;
            m_seq[u]  = s;
         end
      end else begin
         for (int i = 0; i < int'(nd[u]); i++) begin
            if (((m_hold[u] >> i) & 1) == 0) begin
               stp = m_seq[u] ? 1 : 1 + ((m_lfsr[u] >> (2 * i)) & 3);
               m_dice[u][i] = ((m_dice[u][i] - 1 + stp) % fc[u]) + 1;
            end
         end
         m_cnt[u] = m_cnt[u] - 1;
         if (m_cnt[u] == 0) begin
            m_busy[u] = 0;
            m_done[u] = 1;
            m_sum[u]  = 0;
            m_eq[u]   = 1;
            for (int i = 0; i < int'(nd[u]); i++) begin
               m_sum[u] = m_sum[u] + m_dice[u][i];
               if (m_dice[u][i] != m_dice[u][0]) m_eq[u] = 0;
            end
         end
      end
      m_lfsr[u] = lfsr_next(m_lfsr[u]);
   endtask

   function automatic logic [31:0] pack(input int u);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < int'(nd[u]); i++) v = v | (m_dice[u][i] << (i * vw[u]));
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_unit(input int u);
      if (u == 0) begin
         chk("a_dice", 32'(dice_a), pack(0));
         chk("a_sum", 32'(sum_a), m_sum[0]);
         chk("a_all_equal", 32'(eq_a), 32'(m_eq[0]));
         chk("a_busy", 32'(busy_a), 32'(m_busy[0]));
         chk("a_done", 32'(done_a), 32'(m_done[0]));
      end else begin
         chk("b_dice", 32'(dice_b), pack(1));
         chk("b_sum", 32'(sum_b), m_sum[1]);
         chk("b_all_equal", 32'(eq_b), 32'(m_eq[1]));
         chk("b_busy", 32'(busy_b), 32'(m_busy[1]));
         chk("b_done", 32'(done_b), 32'(m_done[1]));
      end
   endtask

   task automatic check_b_ranges();
      bit ok;
      ok = 1;
      for (int i = 0; i < 8; i++) begin
         if (dice_b[2*i +: 2] < 2'd1 || dice_b[2*i +: 2] > 2'd3) ok = 0;
      end
      chk("b_range", 32'(ok), 32'd1);
      chk("b_sum_le_24", 32'(sum_b <= 5'd24), 32'd1);
   endtask

   // One clock edge: the model steps with the inputs that the DUT will sample.
   task automatic tick();
      if (b_active) begin
         roll_b = 1'($urandom_range(0, 1));
         hold_b = 8'($urandom);
      end
      if (!reset) begin
         model_edge(0, roll_a, 32'(hold_a), seq_a);
         model_edge(1, roll_b, 32'(hold_b), seq_b);
      end
      @(posedge clk);
      #1;
      if (b_active) begin
         check_unit(1);
         check_b_ranges();
      end
   endtask

   initial begin
      int unsigned seen [7];
      int ndone, last, got;
      reset  = 1'b1;
      roll_a = 1'b0; seq_a = 1'b0; hold_a = 2'b00;
      roll_b = 1'b0; seq_b = 1'b0; hold_b = 8'h00;
      for (int f = 0; f < 7; f++) seen[f] = 0;
      model_reset();

      // Reset defaults
      tick(); tick();
      reset = 1'b0;
      chk("rst_dice", 32'(dice_a), 32'h09);
      chk("rst_sum", 32'(sum_a), 32'd2);
      check_unit(0);
      check_unit(1);

      // Reset in the middle of a spin
      roll_a = 1'b1; seq_a = 1'b1;
      tick();
      roll_a = 1'b0;
      tick(); tick(); tick();
      check_unit(0);
      reset = 1'b1;
      model_reset();
      #1;
      check_unit(0);
      tick();
      chk("rst_mid_no_done", 32'(done_a), 32'd0);
      check_unit(0);
      reset = 1'b0;

      // Sequential roll, no holds
      roll_a = 1'b1; seq_a = 1'b1; hold_a = 2'b00;
      tick();
      roll_a = 1'b0; seq_a = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         chk("seq_busy_before_edge", 32'(busy_a), 32'd1);
         tick();
         check_unit(0);
      end
      chk("seq_done", 32'(done_a), 32'd1);
      chk("seq_dice", 32'(dice_a), 32'h1B);
      chk("seq_sum", 32'(sum_a), 32'd6);
      chk("seq_eq", 32'(eq_a), 32'd1);
      tick();
      chk("seq_done_one_cycle", 32'(done_a), 32'd0);

      // Sequential roll with die0 held
      roll_a = 1'b1; seq_a = 1'b1; hold_a = 2'b01;
      tick();
      roll_a = 1'b0; hold_a = 2'b00;
      for (int k = 0; k < 8; k++) tick();
      check_unit(0);
      chk("hold_dice", 32'(dice_a), 32'h2B);
      chk("hold_sum", 32'(sum_a), 32'd8);
      chk("hold_eq", 32'(eq_a), 32'd0);

      // Rolls during busy are ignored
      roll_a = 1'b1; seq_a = 1'b1;
      tick();
      roll_a = 1'b0;
      ndone = 0;
      for (int k = 2; k <= 12; k++) begin
         roll_a = (k == 2 || k == 4 || k == 6);
         hold_a = 2'($urandom);
         seq_a  = 1'($urandom);
         tick();
         check_unit(0);
         if (done_a) ndone++;
      end
      roll_a = 1'b0;
      chk("busy_roll_one_done", 32'(ndone), 32'd1);

      // Roll held high: one roll every 9 edges
      roll_a = 1'b1; seq_a = 1'b1; hold_a = 2'b00;
      ndone = 0; last = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         check_unit(0);
         if (done_a) begin
            ndone++;
            if (last >= 0) chk("held_roll_period", 32'(k - last), 32'd9);
            last = k;
         end
      end
      chk("held_roll_done_count", 32'(ndone), 32'd4);
      roll_a = 1'b0;
      got = 0;
      for (int k = 0; k < 20 && got == 0; k++) begin
         tick();
         if (done_a) got = 1;
      end
      chk("held_roll_drain", 32'(got), 32'd1);
      check_unit(0);

      // Random rolls on both rollers
      b_active = 1;
      seq_b = 1'b0;
      for (int r = 0; r < 1000; r++) begin
         roll_a = 1'b1; seq_a = 1'b0; hold_a = 2'b00;
         tick();
         roll_a = 1'b0;
         seq_a = 1'($urandom);
         got = 0;
         for (int k = 0; k < 20 && got == 0; k++) begin
            tick();
            if (done_a) got = 1;
         end
         chk("rand_done_timeout", 32'(got), 32'd1);
         check_unit(0);
         for (int i = 0; i < 2; i++) begin
            chk("rand_a_range", 32'(dice_a[3*i +: 3] >= 3'd1 && dice_a[3*i +: 3] <= 3'd6), 32'd1);
            if (dice_a[3*i +: 3] <= 3'd6) seen[dice_a[3*i +: 3]]++;
         end
      end
      b_active = 1'b0;
      roll_b = 1'b0;
      for (int f = 1; f <= 6; f++) chk("face_seen", 32'(seen[f] > 0), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
